// File: rtl/fazyrv_rf_seq.sv
// ---------------------------------------------------------------------------
// fazyrv_rf_seq
// Chunk-serial access sequencer for the register file. It turns one word
// request (read or write of a 32-bit register) into N = 32/CHUNKSIZE shift
// cycles on the RF's chunked port. Read chunks are collected into a parallel
// word. While busy, this block owns the RF port.
//
// Optional feature: define FAZYRV_RF_SEQ_RMW_EN to add the wmask_i byte-enable
// input. Masked-out bits are rewritten from the current RF value (rf_ra_i).
//
// Ports
//   clk_i, rst_in         clock (rising edge), async active-low reset
//   req_i/we_i/addr_i/    request, direction, register index and write data;
//   wdat_i [/wmask_i]     all captured together in IDLE
//   ack_o                 one-cycle completion pulse
//   busy_o                high in LOAD/RUN/DONE
//   rdat_o                read result, held until the next accepted read
//   rf_shft_o             rotate the RF register by one chunk
//   rf_ram_rstb_o         RF read strobe (LOAD)
//   rf_ram_wstb_o         RF write strobe (RUN, write, addr != 0)
//   rf_rs1_o/rs2_o/rd_o   captured address
//   rf_res_o              write chunk
//   rf_we_o               RF write enable
//   rf_ra_i               current low chunk of register rf_rs1_o
// ---------------------------------------------------------------------------
module fazyrv_rf_seq #(
   parameter int CHUNKSIZE = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_in,
   input  logic                 req_i,
   input  logic                 we_i,
   input  logic [4:0]           addr_i,
   input  logic [31:0]          wdat_i,
`ifdef FAZYRV_RF_SEQ_RMW_EN
   input  logic [3:0]           wmask_i,
`endif
   output logic                 ack_o,
   output logic                 busy_o,
   output logic [31:0]          rdat_o,
   output logic                 rf_shft_o,
   output logic                 rf_ram_rstb_o,
   output logic                 rf_ram_wstb_o,
   output logic [4:0]           rf_rs1_o,
   output logic [4:0]           rf_rs2_o,
   output logic [4:0]           rf_rd_o,
   output logic [CHUNKSIZE-1:0] rf_res_o,
   output logic                 rf_we_o,
   input  logic [CHUNKSIZE-1:0] rf_ra_i
);

   // state  | meaning
   // S_IDLE | waiting for req_i; rf_* strobes low, addresses hold
   // S_LOAD | one cycle read strobe, addresses settle, no shift
   // S_RUN  | N shift cycles, counter 0..N-1
   // S_DONE | one cycle ack_o, rdat_o already updated for reads

   localparam int N  = 32 / CHUNKSIZE;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          we_q, we_d;
   logic [4:0]    addr_q, addr_d;
   logic [31:0]   data_q, data_d;
   logic [31:0]   rdat_q, rdat_d;
   logic [CHUNKSIZE-1:0] wchunk;
`ifdef FAZYRV_RF_SEQ_RMW_EN
   logic [31:0]   mask_q, mask_d;
`endif

   // Shift right by one chunk and insert 'top' at the MSB end. Going through
   // a 64-bit concatenation keeps this legal for CHUNKSIZE = 32 too.
   function automatic logic [31:0] shr_ins(input logic [31:0] v,
                                           input logic [CHUNKSIZE-1:0] top);
      logic [63:0] cat;
      cat = {32'(top), v} >> CHUNKSIZE;
      return cat[31:0];
   endfunction

`ifdef FAZYRV_RF_SEQ_RMW_EN
   function automatic logic [31:0] expand_mask(input logic [3:0] m);
      return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
   endfunction
`endif

   // state register
   always_ff @(posedge clk_i or negedge rst_in) begin
      if (!rst_in) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         rdat_q  <= '0;
`ifdef FAZYRV_RF_SEQ_RMW_EN
         mask_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         rdat_q  <= rdat_d;
`ifdef FAZYRV_RF_SEQ_RMW_EN
         mask_q  <= mask_d;
`endif
      end
   end

   // next-state and datapath
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      data_d  = data_q;
      rdat_d  = rdat_q;
`ifdef FAZYRV_RF_SEQ_RMW_EN
      mask_d  = mask_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (req_i) begin
               we_d    = we_i;
               addr_d  = addr_i;
               data_d  = wdat_i;
               cnt_d   = '0;
`ifdef FAZYRV_RF_SEQ_RMW_EN
               mask_d  = expand_mask(wmask_i);
`endif
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            cnt_d   = '0;
            state_d = S_RUN;
         end
         S_RUN: begin
            // Writes rotate their own copy so the next chunk is always at
            // the bottom; reads pull the RF chunk in at the top.
            if (we_q) begin
               data_d = shr_ins(data_q, data_q[CHUNKSIZE-1:0]);
            end else begin
               data_d = shr_ins(data_q, rf_ra_i);
            end
`ifdef FAZYRV_RF_SEQ_RMW_EN
            mask_d = shr_ins(mask_q, mask_q[CHUNKSIZE-1:0]);
`endif
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = S_DONE;
               if (!we_q) begin
                  rdat_d = data_d;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

`ifdef FAZYRV_RF_SEQ_RMW_EN
   assign wchunk = (data_q[CHUNKSIZE-1:0] & mask_q[CHUNKSIZE-1:0])
                 | (rf_ra_i & ~mask_q[CHUNKSIZE-1:0]);
`else
   assign wchunk = data_q[CHUNKSIZE-1:0];
`endif

   // outputs
   always_comb begin
      ack_o         = 1'b0;
      busy_o        = 1'b0;
      rf_shft_o     = 1'b0;
      rf_ram_rstb_o = 1'b0;
      rf_ram_wstb_o = 1'b0;
      rf_we_o       = 1'b0;
      rf_res_o      = '0;
      case (state_q)
         S_LOAD: begin
            busy_o        = 1'b1;
            rf_ram_rstb_o = 1'b1;
         end
         S_RUN: begin
            busy_o    = 1'b1;
            rf_shft_o = 1'b1;
            if (we_q) begin
               rf_res_o = wchunk;
               // x0 is hardwired zero: sequence runs, nothing is written
               if (addr_q != 5'd0) begin
                  rf_we_o       = 1'b1;
                  rf_ram_wstb_o = 1'b1;
               end
            end
         end
         S_DONE: begin
            busy_o = 1'b1;
            ack_o  = 1'b1;
         end
         default: ;
      endcase
   end

   assign rf_rs1_o = addr_q;
   assign rf_rs2_o = addr_q;
   assign rf_rd_o  = addr_q;
   assign rdat_o   = rdat_q;

endmodule

// File: tb/tb_fazyrv_rf_seq.sv
// Bench for fazyrv_rf_seq: four instances (CHUNKSIZE 2, 1, 4, 32), each with a
// behavioural rotating register file behind it.
module tb_fazyrv_rf_seq;

   logic clk;
   logic rst_n;

   logic        req   [4];
   logic        we_in [4];
   logic [4:0]  addr  [4];
   logic [31:0] wdat  [4];
   logic [3:0]  wmask [4];

   logic        ack   [4];
   logic        busy  [4];
   logic [31:0] rdat  [4];
   logic        shft  [4];
   logic        rstb  [4];
   logic        wstb  [4];
   logic        rfwe  [4];
   logic [4:0]  rs1   [4];
   logic [4:0]  rs2   [4];
   logic [4:0]  rd    [4];

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] rdat;
      int          lat;
      int          shifts;
      int          wes;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] prev_rdat [4];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_ch
      localparam int CS = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 4 : 32;
      logic [CS-1:0] res_l;
      logic [CS-1:0] ra_l;
      logic [CS-1:0] nchunk;
      logic [63:0]   cat;
      logic [31:0]   rf [32];

      fazyrv_rf_seq #(.CHUNKSIZE(CS)) u_dut (
         .clk_i        (clk),
         .rst_in       (rst_n),
         .req_i        (req[g]),
         .we_i         (we_in[g]),
         .addr_i       (addr[g]),
         .wdat_i       (wdat[g]),
`ifdef FAZYRV_RF_SEQ_RMW_EN
         .wmask_i      (wmask[g]),
`endif
         .ack_o        (ack[g]),
         .busy_o       (busy[g]),
         .rdat_o       (rdat[g]),
         .rf_shft_o    (shft[g]),
         .rf_ram_rstb_o(rstb[g]),
         .rf_ram_wstb_o(wstb[g]),
         .rf_rs1_o     (rs1[g]),
         .rf_rs2_o     (rs2[g]),
         .rf_rd_o      (rd[g]),
         .rf_res_o     (res_l),
         .rf_we_o      (rfwe[g]),
         .rf_ra_i      (ra_l)
      );

      // x0 reads as zero and never stores
      assign ra_l   = (rs1[g] == 5'd0) ? '0 : rf[rs1[g]][CS-1:0];
      assign nchunk = rfwe[g] ? res_l : ra_l;
      assign cat    = {32'(nchunk), rf[rs1[g]]} >> CS;

      always @(posedge clk) begin
         if (shft[g] && rs1[g] != 5'd0) rf[rs1[g]] <= cat[31:0];
      end
   end

   function automatic int cs_of(input int g);
      case (g)
         0: return 2;
         1: return 1;
         2: return 4;
         default: return 32;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One full access on instance g. inject > 0 pulses a write request to x7
   // at that many cycles after capture, which must be ignored.
   task automatic access(input int g, input logic w, input logic [4:0] a,
                         input logic [31:0] d, input logic [3:0] m,
                         input logic [31:0] exp_r, input int inject);
      exp_t e;
      int   n, n_cyc, shifts, wes, wss, rss, aerr, acks, bload;
      n        = 32 / cs_of(g);
      e.rdat   = w ? prev_rdat[g] : exp_r;
      e.lat    = n + 2;
      e.shifts = n;
      e.wes    = (w && a != 5'd0) ? n : 0;
      sb.push_back(e);
      if (!w) prev_rdat[g] = exp_r;

      @(posedge clk); #1;
      req[g] = 1'b1; we_in[g] = w; addr[g] = a; wdat[g] = d; wmask[g] = m;
      @(posedge clk); #1;
      req[g] = 1'b0;
      n_cyc = 0; shifts = 0; wes = 0; wss = 0; rss = 0; aerr = 0; acks = 0;
      bload = int'(busy[g]);
      rss   += int'(rstb[g]);
      while (!ack[g] && n_cyc < 200) begin
         @(posedge clk); #1;
         n_cyc++;
         if (n_cyc == inject) begin
            req[g] = 1'b1; we_in[g] = 1'b1; addr[g] = 5'd7; wdat[g] = 32'hFFFF_FFFF;
         end
         if (n_cyc == inject + 1) req[g] = 1'b0;
         shifts += int'(shft[g]);
         wes    += int'(rfwe[g]);
         wss    += int'(wstb[g]);
         rss    += int'(rstb[g]);
         acks   += int'(ack[g]);
         if (busy[g] && (rs1[g] != a || rs2[g] != a || rd[g] != a)) aerr++;
      end
      @(posedge clk); #1;
      chk("ack_pulse_width", 32'(ack[g]), 32'd0);
      chk("busy_after_ack", 32'(busy[g]), 32'd0);
      for (int k = 0; k < 3; k++) begin
         acks += int'(ack[g]);
         @(posedge clk); #1;
      end

      e = sb.pop_front();
      chk("latency", 32'(n_cyc + 1), 32'(e.lat));
      chk("shift_count", 32'(shifts), 32'(e.shifts));
      chk("we_count", 32'(wes), 32'(e.wes));
      chk("wstb_count", 32'(wss), 32'(e.wes));
      chk("rstb_count", 32'(rss), 32'd1);
      chk("busy_in_load", 32'(bload), 32'd1);
      chk("addr_stable", 32'(aerr), 32'd0);
      chk("ack_count", 32'(acks), 32'd1);
      chk("rdat", rdat[g], e.rdat);
   endtask

   int n_rst;

   initial begin
      for (int g = 0; g < 4; g++) begin
         req[g] = 1'b0; we_in[g] = 1'b0; addr[g] = '0; wdat[g] = '0; wmask[g] = 4'hF;
         prev_rdat[g] = '0;
      end
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int g = 0; g < 4; g++) begin
         chk("rst_ack", 32'(ack[g]), 32'd0);
         chk("rst_busy", 32'(busy[g]), 32'd0);
         chk("rst_rdat", rdat[g], 32'd0);
         chk("rst_shft", 32'(shft[g] | rstb[g] | wstb[g] | rfwe[g]), 32'd0);
         chk("rst_addr", 32'(rs1[g]), 32'd0);
      end
      rst_n = 1'b1;

      // basic write/read, CHUNKSIZE 2
      access(0, 1'b1, 5'd5, 32'hDEAD_BEEF, 4'hF, 32'h0, -1);
      chk("rf_x5_after_write", g_ch[0].rf[5], 32'hDEAD_BEEF);
      access(0, 1'b0, 5'd5, 32'h0, 4'hF, 32'hDEAD_BEEF, -1);
      chk("rf_x5_realigned", g_ch[0].rf[5], 32'hDEAD_BEEF);

      // x0
      access(0, 1'b1, 5'd0, 32'hFFFF_FFFF, 4'hF, 32'h0, -1);
      access(0, 1'b0, 5'd0, 32'h0, 4'hF, 32'h0, -1);

      // request while busy is ignored
      access(0, 1'b1, 5'd7, 32'h0BAD_F00D, 4'hF, 32'h0, -1);
      access(0, 1'b0, 5'd5, 32'h0, 4'hF, 32'hDEAD_BEEF, 5);
      chk("rf_x7_untouched", g_ch[0].rf[7], 32'h0BAD_F00D);
      access(0, 1'b0, 5'd7, 32'h0, 4'hF, 32'h0BAD_F00D, -1);

      // reset at RUN count 5
      @(posedge clk); #1;
      req[0] = 1'b1; we_in[0] = 1'b0; addr[0] = 5'd5;
      @(posedge clk); #1;
      req[0] = 1'b0;
      n_rst = 0;
      while (n_rst < 6) begin
         @(posedge clk); #1;
         n_rst++;
      end
      chk("pre_rst_shft", 32'(shft[0]), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(busy[0]), 32'd0);
      chk("mid_rst_strobes", 32'(shft[0] | rstb[0] | wstb[0] | rfwe[0] | ack[0]), 32'd0);
      chk("mid_rst_rdat", rdat[0], 32'd0);
      chk("mid_rst_addr", 32'(rs1[0]), 32'd0);
      @(posedge clk); #1;
      chk("mid_rst_busy_next", 32'(busy[0]), 32'd0);
      rst_n = 1'b1;
      for (int g = 0; g < 4; g++) prev_rdat[g] = '0;
      access(0, 1'b1, 5'd5, 32'h5A5A_A5A5, 4'hF, 32'h0, -1);
      access(0, 1'b0, 5'd5, 32'h0, 4'hF, 32'h5A5A_A5A5, -1);

      // CHUNKSIZE sweep 1/4/32
      for (int g = 1; g < 4; g++) begin
         access(g, 1'b1, 5'd9, 32'h1234_5678, 4'hF, 32'h0, -1);
         access(g, 1'b0, 5'd9, 32'h0, 4'hF, 32'h1234_5678, -1);
      end

`ifdef FAZYRV_RF_SEQ_RMW_EN
      access(0, 1'b1, 5'd3, 32'h1122_3344, 4'hF, 32'h0, -1);
      access(0, 1'b1, 5'd3, 32'hAABB_CCDD, 4'b0101, 32'h0, -1);
      access(0, 1'b0, 5'd3, 32'h0, 4'hF, 32'h11BB_33DD, -1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
